// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 serial transmitter for the SoC UART peripheral.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line high, waiting for a buffered byte
// START  | start bit (low) for one bit time
// DATA   | 8 data bits, LSB first
// PARITY | even parity of the data byte (UART_TX_PARITY_EN only)
// STOP   | stop bit (high); pops the next byte here for gap-free frames
module uart_tx #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_valid_i,
    input  logic [7:0]                    wr_data_i,
    output logic                          wr_ready_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          tx_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int PW           = $clog2(FIFO_DEPTH);
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
    logic          parity;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          bit_done;

    assign wr_ready_o = (fifo_count_o != FIFO_FULL);
    assign push       = wr_valid_i && wr_ready_o;
    assign bit_done   = (baud_cnt == BAUD_LAST);
    assign pop        = (fifo_count_o != '0) &&
                        ((state == IDLE) || ((state == STOP) && bit_done));

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    // Pointers are PW bits wide, so they wrap modulo FIFO_DEPTH on their own.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count_o <= fifo_count_o + 1'b1;
                2'b01:   fifo_count_o <= fifo_count_o - 1'b1;
                default: fifo_count_o <= fifo_count_o;
            endcase
        end
    end

    // tx_o is registered from the current state, so the line lags the FSM by one clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            busy_o <= (state != IDLE) || (fifo_count_o != '0);
            case (state)
                IDLE: begin
                    tx_o     <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity <= ^mem[rd_ptr];
`endif
                        state <= START;
                    end
                end
                START: begin
                    tx_o <= 1'b0;
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx_o <= shift[0];
                    if (bit_done) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx_o <= parity;
                    if (bit_done) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    tx_o <= 1'b1;
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                            parity <= ^mem[rd_ptr];
`endif
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_o     <= 1'b1;
                    baud_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at 10 clocks per bit, with a line decoder.
// Define UART_TX_PARITY_EN for both bench and RTL to exercise the parity frame.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME  = 11 * CPB;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int FRAME  = 10 * CPB;
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       busy;
    logic [3:0] fifo_count;
    logic       tx;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    uart_tx #(
        .CLK_FREQ_HZ(1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_valid_i  (wr_valid),
        .wr_data_i   (wr_data),
        .wr_ready_o  (wr_ready),
        .busy_o      (busy),
        .fifo_count_o(fifo_count),
        .tx_o        (tx)
    );

    always #5 if (clk_en) clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: hunts for a start bit, then samples each bit at its centre.
    logic [7:0] rx_q[$];
    bit         stop_q[$];
    bit         par_q[$];
    int         start_cyc[$];
    int         rx_phase = 0;
    int         rx_cnt = 0;
    int         rx_bit = 0;
    logic [7:0] rx_sh = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            rx_phase = 0;
        end else begin
            case (rx_phase)
                0: if (tx === 1'b0) begin
                    rx_phase = 1;
                    rx_cnt = 0;
                    start_cyc.push_back(cyc);
                end
                1: begin
                    rx_cnt++;
                    if (rx_cnt == CPB / 2) begin
                        rx_cnt = 0;
                        rx_bit = 0;
                        rx_phase = (tx === 1'b0) ? 2 : 0;
                    end
                end
                2: begin
                    rx_cnt++;
                    if (rx_cnt == CPB) begin
                        rx_cnt = 0;
                        rx_sh = {tx, rx_sh[7:1]};
                        rx_bit++;
                        if (rx_bit == 8) rx_phase = PAR_EN ? 3 : 4;
                    end
                end
                3: begin
                    rx_cnt++;
                    if (rx_cnt == CPB) begin
                        rx_cnt = 0;
                        par_q.push_back(tx);
                        rx_phase = 4;
                    end
                end
                default: begin
                    rx_cnt++;
                    if (rx_cnt == CPB) begin
                        rx_q.push_back(rx_sh);
                        stop_q.push_back(tx);
                        rx_phase = 0;
                    end
                end
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_data  = b;
        wr_valid = 1'b1;
        tick(1);
        wr_valid = 1'b0;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        stop_q.delete();
        par_q.delete();
        start_cyc.delete();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            tick(1);
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s wait_idle: busy=%b after %0d clks, expected 0", name, busy, n);
        end
    endtask

    task automatic wait_rx(input string name, input int want);
        int n = 0;
        while (rx_q.size() < want && n < 3000) begin
            tick(1);
            n++;
        end
        vectors++;
        if (rx_q.size() != want) begin
            miscompares++;
            $display("FAIL %s rx_count: got %0d frames, expected %0d", name, rx_q.size(), want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        vectors++;
        if (tx !== 1'b1) begin
            miscompares++;
            $display("FAIL reset tx: got %b expected 1", tx);
        end
        vectors++;
        if (wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset wr_ready: got %b expected 1", wr_ready);
        end
        vectors++;
        if (fifo_count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset fifo_count: got %0d expected 0", fifo_count);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset busy: got %b expected 0", busy);
        end
        #5 rst = 1'b0;
        #5 clk_en = 1'b1;
        tick(3);
    endtask

    task automatic test_single();
        logic [7:0] b;
        b = 8'hA5;
        clear_rx();
        push_byte(b);                          // edge k; now just after k
        vectors++;
        if (fifo_count !== 4'd1) begin
            miscompares++;
            $display("FAIL single count_k: got %0d expected 1", fifo_count);
        end
        tick(1);                               // k+1
        vectors++;
        if ({tx, fifo_count, busy} !== {1'b1, 4'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL single k+1 tx/count/busy: got %b/%0d/%b expected 1/0/1", tx, fifo_count, busy);
        end
        tick(1);                               // k+2
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL single start_first tx: got %b expected 0", tx);
        end
        tick(9);                               // k+11
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL single start_last tx: got %b expected 0", tx);
        end
        tick(1);                               // k+12
        vectors++;
        if (tx !== 1'b1) begin
            miscompares++;
            $display("FAIL single bit0_first tx: got %b expected 1", tx);
        end
        tick(5);                               // k+17, centre of bit 0
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (tx !== b[i]) begin
                miscompares++;
                $display("FAIL single data_bit%0d tx: got %b expected %b", i, tx, b[i]);
            end
            tick(CPB);
        end
`ifdef UART_TX_PARITY_EN
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL single parity tx: got %b expected 0", tx);
        end
        tick(CPB);
`endif
        vectors++;                             // centre of stop bit
        if (tx !== 1'b1) begin
            miscompares++;
            $display("FAIL single stop tx: got %b expected 1", tx);
        end
        tick(4);                               // last edge of the frame
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single busy_end: got %b expected 1", busy);
        end
        tick(1);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single busy_after: got %b expected 0", busy);
        end
        wait_rx("single", 1);
        vectors++;
        if (rx_q.size() > 0 && rx_q[0] !== b) begin
            miscompares++;
            $display("FAIL single rx_byte: got %h expected %h", rx_q[0], b);
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] bytes [10];
        int waited;
        bit stop_ok;
        bytes = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h5A, 8'hC3};
        wait_idle("fifo_full");
        clear_rx();
        for (int i = 0; i < 9; i++) begin
            vectors++;
            if (wr_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL fifo_full ready_push%0d: got %b expected 1", i, wr_ready);
            end
            push_byte(bytes[i]);
        end
        vectors++;
        if ({fifo_count, wr_ready} !== {4'd8, 1'b0}) begin
            miscompares++;
            $display("FAIL fifo_full full: count=%0d ready=%b expected 8/0", fifo_count, wr_ready);
        end
        wr_data  = bytes[9];
        wr_valid = 1'b1;
        waited   = 0;
        while (wr_ready !== 1'b1 && waited < 500) begin
            tick(1);
            waited++;
        end
        tick(1);
        wr_valid = 1'b0;
        vectors++;
        if (waited != FRAME - 7) begin
            miscompares++;
            $display("FAIL fifo_full hold_clks: got %0d expected %0d", waited, FRAME - 7);
        end
        wait_rx("fifo_full", 10);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (i >= rx_q.size() || rx_q[i] !== bytes[i]) begin
                miscompares++;
                $display("FAIL fifo_full order%0d: got %h expected %h", i,
                         (i < rx_q.size()) ? rx_q[i] : 8'hxx, bytes[i]);
            end
        end
        stop_ok = 1'b1;
        foreach (stop_q[i]) if (stop_q[i] !== 1'b1) stop_ok = 1'b0;
        vectors++;
        if (stop_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL fifo_full stop_bits: got %b expected 1", stop_ok);
        end
    endtask

    task automatic test_back_to_back(input string name, input logic [7:0] b0,
                                     input logic [7:0] b1);
        wait_idle(name);
        clear_rx();
        push_byte(b0);
        push_byte(b1);
        wait_rx(name, 2);
        vectors++;
        if (rx_q.size() == 2 && {rx_q[0], rx_q[1]} !== {b0, b1}) begin
            miscompares++;
            $display("FAIL %s bytes: got %h %h expected %h %h", name, rx_q[0], rx_q[1], b0, b1);
        end
        vectors++;
        if (start_cyc.size() < 2 || start_cyc[1] - start_cyc[0] != FRAME) begin
            miscompares++;
            $display("FAIL %s frame_spacing: got %0d expected %0d", name,
                     (start_cyc.size() < 2) ? -1 : start_cyc[1] - start_cyc[0], FRAME);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit low_seen;
        wait_idle("rst_mid");
        clear_rx();
        push_byte(8'h3C);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);                      // k+3
        vectors++;
        if (fifo_count !== 4'd3) begin
            miscompares++;
            $display("FAIL rst_mid queued: got %0d expected 3", fifo_count);
        end
        tick(22);                              // k+25: inside data bit 1 (0)
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid pre_tx: got %b expected 0", tx);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({tx, fifo_count, busy, wr_ready} !== {1'b1, 4'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_mid async: tx/count/busy/ready=%b/%0d/%b/%b expected 1/0/0/1",
                     tx, fifo_count, busy, wr_ready);
        end
        tick(3);
        rst = 1'b0;
        clear_rx();
        low_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (tx !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
        end
        vectors++;
        if (low_seen !== 1'b0 || rx_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_mid quiet: activity=%b frames=%0d expected 0/0", low_seen, rx_q.size());
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        test_back_to_back("parity", 8'h07, 8'h03);
        vectors++;
        if (par_q.size() != 2 || {par_q[0], par_q[1]} !== 2'b10) begin
            miscompares++;
            $display("FAIL parity bits: got %0d entries %b%b expected 2 entries 10",
                     par_q.size(), (par_q.size() > 0) ? par_q[0] : 1'b0,
                     (par_q.size() > 1) ? par_q[1] : 1'b0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fifo_full();
        test_back_to_back("b2b", 8'h00, 8'hFF);
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        wait_idle("final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
